// File: rtl/inst_fetch_if.sv
// Instruction fetch bus bundle: memory request/response channel, redirect
// input and the instruction stream toward the core.
interface inst_fetch_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  mem_req;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] inst_address;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_address,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_address,
        output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues in-order memory requests, buffers responses
// with their addresses in a FIFO and flushes the stream on redirect.
module inst_fetch #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 2;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [SW-1:0] sum_t;

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    ptr_t                  wr_q, wr_d, rd_q, rd_d;
    ptr_t                  aqw_q, aqw_d, aqr_q, aqr_d;
    cnt_t                  count_q, count_d, out_q, out_d, disc_q, disc_d;
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DATA_WIDTH-1:0] iaddr_q [DEPTH];
    logic [DATA_WIDTH-1:0] aq_q    [DEPTH];

    sum_t inflight, pending;
    logic accept, rsp_drop, rsp_keep, pop;

    always_comb begin
        pending  = sum_t'(out_q) + sum_t'(disc_q);
        inflight = pending + sum_t'(count_q);
    end

    // Stale responses still in flight after a redirect reserve buffer space too.
    assign bus.mem_req      = rst && !bus.redirect && (inflight < sum_t'(DEPTH));
    assign bus.mem_addr     = pc_q;
    assign bus.inst_valid   = (count_q != '0);
    assign bus.inst         = data_q[rd_q];
    assign bus.inst_address = iaddr_q[rd_q];

    assign accept   = bus.mem_req && bus.mem_gnt;
    assign rsp_drop = bus.mem_rvalid && (disc_q != '0);
    assign rsp_keep = bus.mem_rvalid && (disc_q == '0) && (out_q != '0);
    assign pop      = bus.inst_valid && bus.inst_ready;

    always_comb begin
        pc_d    = pc_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        aqw_d   = aqw_q;
        aqr_d   = aqr_q;
        count_d = count_q;
        out_d   = out_q;
        disc_d  = disc_q;

        if (accept) begin
            pc_d  = pc_q + DATA_WIDTH'(4);
            aqw_d = aqw_q + 1'b1;
            out_d = out_q + 1'b1;
        end
        if (rsp_keep) begin
            aqr_d = aqr_q + 1'b1;
            wr_d  = wr_q + 1'b1;
            out_d = out_d - 1'b1;
        end
        if (rsp_drop) begin
            disc_d = disc_q - 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({rsp_keep, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A response arriving in the redirect cycle is already stale.
        if (bus.redirect) begin
            pc_d    = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
            wr_d    = '0;
            rd_d    = '0;
            aqw_d   = '0;
            aqr_d   = '0;
            count_d = '0;
            out_d   = '0;
            disc_d  = cnt_t'(pending - sum_t'(bus.mem_rvalid && (pending != '0)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            wr_q    <= '0;
            rd_q    <= '0;
            aqw_q   <= '0;
            aqr_q   <= '0;
            count_q <= '0;
            out_q   <= '0;
            disc_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                iaddr_q[i] <= '0;
                aq_q[i]    <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            aqw_q   <= aqw_d;
            aqr_q   <= aqr_d;
            count_q <= count_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            if (accept) begin
                aq_q[aqw_q] <= pc_q;
            end
            if (rsp_keep && !bus.redirect) begin
                data_q[wr_q]  <= bus.mem_rdata;
                iaddr_q[wr_q] <= aq_q[aqr_q];
            end
        end
    end
endmodule
